// File: rtl/mem_wb_writeback.sv
// MEM/WB stage register, write-back value select/extension, halt FSM and
// retire/bubble statistics. Defining WB_STAT_EN builds the statistics counters.
module mem_wb_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        clear,
    input  logic        restart,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rw,
    input  logic        mem_reg_we,
    input  logic [1:0]  mem_wsel,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [11:0] mem_pc_4,
    input  logic        mem_halt,
    output logic [4:0]  rW,
    output logic        WE,
    output logic [31:0] w,
    output logic        wb_valid,
    output logic        halted,
    output logic [31:0] retired_cnt,
    output logic [31:0] bubble_cnt
);
    // state    | meaning
    // S_RUN    | normal operation, stage follows restart/clear/go
    // S_HALTED | halt instruction retired; stage forced to bubble until restart
    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rw;
        logic        reg_we;
        logic [1:0]  wsel;
        logic [31:0] alu_result;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [11:0] pc_4;
        logic        halt;
    } stage_t;

    state_e state_q, state_d;
    stage_t stage_q, stage_d;
    logic   halt_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    // The halt entry leaves the stage on the same edge that enters HALTED.
    assign halt_now = (state_q == S_RUN) && stage_q.valid && stage_q.halt;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        if (restart) begin
            state_d = S_RUN;
            stage_d = '0;
        end else if (state_q == S_HALTED || halt_now) begin
            state_d = S_HALTED;
            stage_d = '0;
        end else if (clear) begin
            stage_d = '0;
        end else if (go) begin
            stage_d.valid       = mem_valid;
            stage_d.rw          = mem_rw;
            stage_d.reg_we      = mem_reg_we;
            stage_d.wsel        = mem_wsel;
            stage_d.alu_result  = mem_alu_result;
            stage_d.rdata       = mem_rdata;
            stage_d.size        = mem_size;
            stage_d.is_unsigned = mem_unsigned;
            stage_d.pc_4        = mem_pc_4;
            stage_d.halt        = mem_halt;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = stage_q.rdata[{stage_q.alu_result[1:0], 3'b000} +: 8];
        ld_half = stage_q.alu_result[1] ? stage_q.rdata[31:16] : stage_q.rdata[15:0];
        case (stage_q.size)
            2'd1:    ld_ext = stage_q.is_unsigned ? {16'h0000, ld_half}
                                                  : {{16{ld_half[15]}}, ld_half};
            2'd2:    ld_ext = stage_q.is_unsigned ? {24'h000000, ld_byte}
                                                  : {{24{ld_byte[7]}}, ld_byte};
            default: ld_ext = stage_q.rdata;
        endcase
        case (stage_q.wsel)
            2'd1:    w = ld_ext;
            2'd2:    w = {20'h00000, stage_q.pc_4};
            default: w = stage_q.alu_result;
        endcase
    end

    assign rW       = stage_q.rw;
    assign WE       = stage_q.valid & stage_q.reg_we & ~stage_q.halt & (stage_q.rw != 5'd0);
    assign wb_valid = stage_q.valid;
    assign halted   = (state_q == S_HALTED);

`ifdef WB_STAT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] bubble_q, bubble_d;
    logic        stage_moves;

    // A held (stalled) entry is counted only when it finally leaves the stage.
    assign stage_moves = go | clear | halt_now;

    always_comb begin
        retired_d = retired_q;
        bubble_d  = bubble_q;
        if (restart) begin
            retired_d = '0;
            bubble_d  = '0;
        end else if (state_q == S_RUN) begin
            if (stage_q.valid && stage_moves) retired_d = retired_q + 32'd1;
            if (!stage_q.valid)               bubble_d  = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else begin
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    assign retired_cnt = retired_q;
    assign bubble_cnt  = bubble_q;
`else
    assign retired_cnt = 32'h0;
    assign bubble_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Scoreboard bench for mem_wb_writeback: directed test-plan cases then random
// traffic, checked against a behavioural model of the write-back stage.
module tb_mem_wb_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0, clear = 1'b0, restart = 1'b0;
    logic        mem_valid = 1'b0, mem_reg_we = 1'b0, mem_unsigned = 1'b0, mem_halt = 1'b0;
    logic [4:0]  mem_rw = '0;
    logic [1:0]  mem_wsel = '0, mem_size = '0;
    logic [31:0] mem_alu_result = '0, mem_rdata = '0;
    logic [11:0] mem_pc_4 = '0;
    logic [4:0]  rW;
    logic        WE, wb_valid, halted;
    logic [31:0] w, retired_cnt, bubble_cnt;

    mem_wb_writeback dut (
        .clk(clk), .rst(rst), .go(go), .clear(clear), .restart(restart),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_reg_we(mem_reg_we),
        .mem_wsel(mem_wsel), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_pc_4(mem_pc_4),
        .mem_halt(mem_halt), .rW(rW), .WE(WE), .w(w), .wb_valid(wb_valid),
        .halted(halted), .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rw;
        logic        we;
        logic [31:0] w;
        logic        halted;
        logic [31:0] ret;
        logic [31:0] bub;
    } exp_t;

    exp_t exp_q[$];
    int   c_total = 0;
    int   c_pass  = 0;

    // Reference model: what the WB stage holds, expressed as a retired value.
    bit        m_valid, m_we, m_halt, m_halted;
    bit [4:0]  m_rw;
    bit [31:0] m_w, m_ret, m_bub;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        c_total++;
        if (act === exp) c_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] wb_value(input logic [1:0] wsel, input logic [1:0] size,
                                             input logic uns, input logic [31:0] alu,
                                             input logic [31:0] rdata, input logic [11:0] pc4);
        int unsigned off;
        logic [31:0] v;
        off = alu % 4;
        if (wsel == 2'd1) begin
            if (size == 2'd2) begin
                v = (rdata >> (8 * off)) & 32'h0000_00FF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                v = (rdata >> ((off >= 2) ? 16 : 0)) & 32'h0000_FFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = rdata;
            end
        end else if (wsel == 2'd2) begin
            v = 32'(pc4);
        end else begin
            v = alu;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_halt = 0; m_halted = 0;
        m_rw = 0; m_w = 0; m_ret = 0; m_bub = 0;
    endtask

    task automatic model_apply();
        exp_t e;
        bit leaving;
        if (restart) begin
            model_reset();
        end else begin
            if (!m_halted) begin
                leaving = go || clear || (m_valid && m_halt);
                if (m_valid && leaving) m_ret++;
                if (!m_valid) m_bub++;
            end
            if (m_halted || (m_valid && m_halt)) begin
                m_halted = 1;
                m_valid  = 0;
            end else if (clear) begin
                m_valid = 0;
            end else if (go) begin
                m_valid = mem_valid;
                m_rw    = mem_rw;
                m_we    = mem_reg_we;
                m_halt  = mem_halt;
                m_w     = wb_value(mem_wsel, mem_size, mem_unsigned, mem_alu_result, mem_rdata, mem_pc_4);
            end
        end
        e.valid  = m_valid;
        e.rw     = m_rw;
        e.we     = m_valid && m_we && !m_halt && (m_rw != 0);
        e.w      = m_w;
        e.halted = m_halted;
`ifdef WB_STAT_EN
        e.ret = m_ret;
        e.bub = m_bub;
`else
        e.ret = 32'h0;
        e.bub = 32'h0;
`endif
        exp_q.push_back(e);
    endtask

    // Inputs are set at a negedge; the expectation for the next posedge is queued.
    task automatic step();
        model_apply();
        @(negedge clk);
    endtask

    task automatic set_ctl(input logic g, input logic c, input logic r);
        go = g; clear = c; restart = r;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rw, input logic we,
                             input logic [1:0] wsel, input logic [31:0] alu,
                             input logic [31:0] rdata, input logic [1:0] size,
                             input logic uns, input logic [11:0] pc4, input logic hlt);
        mem_valid = v; mem_rw = rw; mem_reg_we = we; mem_wsel = wsel;
        mem_alu_result = alu; mem_rdata = rdata; mem_size = size;
        mem_unsigned = uns; mem_pc_4 = pc4; mem_halt = hlt;
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_rW"}, 32'(rW), 32'h0);
        check32({tag, "_WE"}, 32'(WE), 32'h0);
        check32({tag, "_w"}, w, 32'h0);
        check32({tag, "_wb_valid"}, 32'(wb_valid), 32'h0);
        check32({tag, "_halted"}, 32'(halted), 32'h0);
        check32({tag, "_retired"}, retired_cnt, 32'h0);
        check32({tag, "_bubble"}, bubble_cnt, 32'h0);
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check32("wb_valid", 32'(wb_valid), 32'(e.valid));
            check32("WE", 32'(WE), 32'(e.we));
            check32("halted", 32'(halted), 32'(e.halted));
            check32("retired_cnt", retired_cnt, e.ret);
            check32("bubble_cnt", bubble_cnt, e.bub);
            if (e.valid) begin
                check32("rW", 32'(rW), 32'(e.rw));
                check32("w", w, e.w);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] r1, r2;
        model_reset();
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // ALU write, then an idle go cycle so it retires
        set_ctl(1, 0, 0);
        set_instr(1, 5'd8, 1, 2'd0, 32'h1234, 32'h0, 2'd0, 0, 12'h0, 0); step();
        set_instr(0, 5'd0, 0, 2'd0, 32'h0, 32'h0, 2'd0, 0, 12'h0, 0);    step();
        // byte loads, signed and unsigned
        set_instr(1, 5'd9, 1, 2'd1, 32'h0000_1002, 32'h0080_0000, 2'd2, 0, 12'h0, 0); step();
        set_instr(1, 5'd9, 1, 2'd1, 32'h0000_1002, 32'h0080_0000, 2'd2, 1, 12'h0, 0); step();
        // half load at offset 2 (offset[0] ignored on the second), then jal
        set_instr(1, 5'd10, 1, 2'd1, 32'h0000_2002, 32'h8001_0000, 2'd1, 0, 12'h0, 0); step();
        set_instr(1, 5'd10, 1, 2'd1, 32'h0000_2003, 32'h8001_7FFF, 2'd1, 1, 12'h0, 0); step();
        set_instr(1, 5'd31, 1, 2'd2, 32'hDEAD_BEEF, 32'h0, 2'd0, 0, 12'h104, 0); step();
        // reserved wsel/size
        set_instr(1, 5'd3, 1, 2'd3, 32'hCAFE_0001, 32'h5555_AAAA, 2'd3, 0, 12'h0, 0); step();
        set_instr(1, 5'd4, 1, 2'd1, 32'h0000_0001, 32'h1234_5678, 2'd3, 0, 12'h0, 0); step();
        // $zero write suppressed
        set_instr(1, 5'd0, 1, 2'd0, 32'h7777, 32'h0, 2'd0, 0, 12'h0, 0); step();
        // clear wins over go, three cycles
        set_ctl(1, 1, 0);
        set_instr(1, 5'd5, 1, 2'd0, 32'h55, 32'h0, 2'd0, 0, 12'h0, 0);
        step(); step(); step();
        // stall a writing entry for five cycles
        set_ctl(1, 0, 0);
        set_instr(1, 5'd12, 1, 2'd0, 32'hABCD_0012, 32'h0, 2'd0, 0, 12'h0, 0); step();
        set_ctl(0, 0, 0);
        set_instr(1, 5'd13, 1, 2'd0, 32'h1111_2222, 32'h0, 2'd0, 0, 12'h0, 0);
        for (int i = 0; i < 5; i++) step();
        set_ctl(1, 0, 0); step();
        // halt, then 10 go cycles with valid traffic, then restart
        set_instr(1, 5'd2, 1, 2'd0, 32'h0, 32'h0, 2'd0, 0, 12'h0, 1); step();
        set_instr(1, 5'd14, 1, 2'd0, 32'h4444, 32'h0, 2'd0, 0, 12'h0, 0);
        for (int i = 0; i < 11; i++) step();
        set_ctl(1, 0, 1); step();
        set_ctl(1, 0, 0); step(); step();
        // restart with the halt entry in the stage
        set_instr(1, 5'd2, 0, 2'd0, 32'h0, 32'h0, 2'd0, 0, 12'h0, 1); step();
        set_ctl(1, 0, 1);
        set_instr(1, 5'd15, 1, 2'd0, 32'h5151, 32'h0, 2'd0, 0, 12'h0, 0); step();
        set_ctl(1, 0, 0); step(); step();
        // restart mid-stall
        set_ctl(0, 0, 0); step(); step();
        set_ctl(0, 0, 1); step();
        set_ctl(1, 0, 0); step();
        // asynchronous reset mid-stall
        set_instr(1, 5'd16, 1, 2'd0, 32'h6666, 32'h0, 2'd0, 0, 12'h0, 0); step();
        set_ctl(0, 0, 0); step();
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        #1 rst = 1'b0;
        exp_q.delete();
        model_reset();
        step();
        set_ctl(1, 0, 0); step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            go      = ($urandom_range(0, 99) < 80);
            clear   = ($urandom_range(0, 99) < 8);
            restart = m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 2);
            mem_valid      = ($urandom_range(0, 7) != 0);
            mem_rw         = r1[4:0];
            mem_reg_we     = r1[5];
            mem_wsel       = r1[7:6];
            mem_size       = r1[9:8];
            mem_unsigned   = r1[10];
            mem_pc_4       = r1[27:16];
            mem_halt       = ($urandom_range(0, 99) < 4);
            mem_alu_result = r2;
            mem_rdata      = $urandom;
            step();
        end

        set_ctl(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", c_pass, c_total);
        $finish;
    end
endmodule
